// File: rtl/inv_sbox_serial.sv
// inv_sbox_serial: iterative AES InvSubBytes engine for a 128-bit state.
// A state is accepted over a valid/ready handshake, substituted in place
// BYTES_PER_CYCLE bytes per clock, then presented until the consumer takes it.
// Per byte: inverse affine map followed by the GF(2^8) multiplicative inverse
// (AES polynomial, inv(0) = 0), computed as x^254 through a square-and-multiply
// chain of combinational GF(2^8) multipliers.
// Optional build macro INV_SBOX_FWD_MODE_EN adds a 'mode' input: mode=1 selects
// the forward S-box (inverse, then forward affine map) on the same inverters.
//
// state  | meaning
// IDLE   | waiting for a state, in_ready high
// BUSY   | substituting one byte group per cycle
// DONE   | result on out_data, out_valid high until out_ready
module inv_sbox_serial #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef INV_SBOX_FWD_MODE_EN
  input  logic         mode,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NGRP  = 16 / BYTES_PER_CYCLE;
  localparam int GRP_W = 8 * BYTES_PER_CYCLE;
  localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGRP - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("inv_sbox_serial: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} fsm_e;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^(2^k - 1) grows to x^127 over six steps; one more squaring gives x^254.
  function automatic logic [7:0] gf_inv_8(input logic [7:0] x);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < 6; i++) y = gf_mul(gf_mul(y, y), x);
    return gf_mul(y, y);
  endfunction

`ifdef INV_SBOX_FWD_MODE_EN
  function automatic logic [7:0] fwd_affine(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction
  logic mode_q, mode_d;
`endif

  fsm_e             fsm_q, fsm_d;
  logic [127:0]     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [GRP_W-1:0] grp_in, grp_out;

  // Select the byte group addressed by the counter.
  always_comb begin
    grp_in = '0;
    for (int g = 0; g < NGRP; g++) begin
      if (cnt_q == CNT_W'(g)) grp_in = state_q[g*GRP_W +: GRP_W];
    end
  end

  for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_lane
    logic [7:0] pre, inv_y;
`ifdef INV_SBOX_FWD_MODE_EN
    assign pre   = mode_q ? grp_in[8*b +: 8] : inv_affine(grp_in[8*b +: 8]);
    assign inv_y = gf_inv_8(pre);
    assign grp_out[8*b +: 8] = mode_q ? fwd_affine(inv_y) : inv_y;
`else
    assign pre   = inv_affine(grp_in[8*b +: 8]);
    assign inv_y = gf_inv_8(pre);
    assign grp_out[8*b +: 8] = inv_y;
`endif
  end

  // Next-state logic: accept, group-by-group substitution, output handshake.
  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef INV_SBOX_FWD_MODE_EN
    mode_d      = mode_q;
`endif
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d    = in_data;
          cnt_d      = '0;
          fsm_d      = S_BUSY;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef INV_SBOX_FWD_MODE_EN
          mode_d     = mode;
`endif
        end
      end
      S_BUSY: begin
        for (int g = 0; g < NGRP; g++) begin
          if (cnt_q == CNT_W'(g)) state_d[g*GRP_W +: GRP_W] = grp_out;
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          fsm_d       = S_DONE;
          out_valid_d = 1'b1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          fsm_d       = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // FSM, state register and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      state_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef INV_SBOX_FWD_MODE_EN
      mode_q      <= 1'b0;
`endif
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef INV_SBOX_FWD_MODE_EN
      mode_q      <= mode_d;
`endif
    end
  end

  if (NGRP > 1) begin : g_cnt
    // Group counter; absent when the whole state is done in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
    end
  end else begin : g_no_cnt
    assign cnt_q = '0;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inv_sbox_serial.sv
// Directed testbench for inv_sbox_serial: three instances (1, 4 and 16 bytes
// per cycle) sharing clock and reset, checked against the FIPS-197 inverse table.
// Mode tests are compiled when INV_SBOX_FWD_MODE_EN is defined.
module tb_inv_sbox_serial;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_data   [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_data  [3];
  logic         busy      [3];
`ifdef INV_SBOX_FWD_MODE_EN
  logic         mode      [3];
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] inv_tab [256];

  for (genvar d = 0; d < 3; d++) begin : g_dut
    inv_sbox_serial #(.BYTES_PER_CYCLE((d == 0) ? 1 : (d == 1) ? 4 : 16)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef INV_SBOX_FWD_MODE_EN
      .mode      (mode[d]),
`endif
      .in_valid  (in_valid[d]),
      .in_ready  (in_ready[d]),
      .in_data   (in_data[d]),
      .out_valid (out_valid[d]),
      .out_ready (out_ready[d]),
      .out_data  (out_data[d]),
      .busy      (busy[d])
    );
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_of(input logic [127:0] x);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = inv_tab[x[8*k +: 8]];
    return r;
  endfunction

  // One complete transaction on instance d with out_ready raised once out_valid shows.
  task automatic run(input int d, input logic [127:0] data, input logic [127:0] exp,
                     input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, 128'(in_ready[d]), 128'd1);
    in_valid[d]  = 1'b1;
    in_data[d]   = data;
    out_ready[d] = 1'b0;
    @(negedge clk);
    in_valid[d] = 1'b0;
    lat = 0;
    while (out_valid[d] !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 128'(lat), 128'(exp_lat));
    check({tag, " out_data"}, out_data[d], exp);
    check({tag, " busy in done"}, 128'(busy[d]), 128'd1);
    out_ready[d] = 1'b1;
    @(negedge clk);
    out_ready[d] = 1'b0;
    check({tag, " busy/valid/ready after handshake"},
          128'({busy[d], out_valid[d], in_ready[d]}), 128'(3'b001));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] data_a, data_b, data_c, d256;
    int lat;

    inv_tab = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b0;
`ifdef INV_SBOX_FWD_MODE_EN
      mode[d]      = 1'b0;
`endif
    end

    // Reset values on every instance.
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("reset flags dut%0d", d),
            128'({in_ready[d], out_valid[d], busy[d]}), 128'(3'b100));
      check($sformatf("reset out_data dut%0d", d), out_data[d], 128'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // 1 byte/cycle: 0x63 maps to 0x00, 16-cycle latency.
    run(0, {16{8'h63}}, 128'd0, 16, "bpc1 all63");

    // 4 bytes/cycle: 00/7C/16/ED -> 52/01/FF/53.
    run(1, {4{32'hED167C00}}, {4{32'h53FF0152}}, 4, "bpc4 pattern");

    // 16 bytes/cycle: every byte value through the full table.
    for (int s = 0; s < 16; s++) begin
      for (int k = 0; k < 16; k++) d256[8*k +: 8] = 8'(16 * s + k);
      run(2, d256, exp_of(d256), 1, $sformatf("bpc16 all256 state%0d", s));
    end

    // Back-pressure in DONE with in_valid pulses that must not be captured.
    data_a = 128'h0f0e0d0c0b0a09080706050403020100;
    data_b = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data[1]  = data_a;
    @(negedge clk);
    in_valid[1] = 1'b0;
    lat = 0;
    while (out_valid[1] !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check("bp latency", 128'(lat), 128'd4);
    for (int i = 0; i < 10; i++) begin
      in_valid[1] = (i % 3 == 0);
      in_data[1]  = data_b;
      @(negedge clk);
      check($sformatf("bp hold out_data %0d", i), out_data[1], exp_of(data_a));
      check($sformatf("bp hold valid/ready %0d", i),
            128'({out_valid[1], in_ready[1]}), 128'(2'b10));
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    check("bp handshake flags", 128'({out_valid[1], in_ready[1], busy[1]}), 128'(3'b010));
    @(negedge clk);
    check("bp no capture flags", 128'({out_valid[1], in_ready[1], busy[1]}), 128'(3'b010));
    run(1, data_b, exp_of(data_b), 4, "bp next accept");

    // Asynchronous reset with the 1 byte/cycle counter at 7.
    data_c = {16{8'h52}};
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = data_c;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    check("mid partial state", out_data[0], {{9{8'h52}}, {7{8'h48}}});
    #2 rst_n = 1'b0;
    #1;
    check("async reset out_data", out_data[0], 128'd0);
    check("async reset flags", 128'({out_valid[0], in_ready[0], busy[0]}), 128'(3'b010));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("no output after abort", 128'(out_valid[0]), 128'd0);
    run(0, data_a, exp_of(data_a), 16, "post reset bpc1");

`ifdef INV_SBOX_FWD_MODE_EN
    mode[2] = 1'b1;
    run(2, {8{16'h5300}}, {8{16'hED63}}, 1, "mode fwd");
    mode[2] = 1'b0;
    run(2, {8{16'h5300}}, {8{16'h5052}}, 1, "mode inv");
    mode[1] = 1'b1;
    run(1, {8{16'h5300}}, {8{16'hED63}}, 4, "mode fwd bpc4");
    mode[1] = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
